// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths, write request type and grant source encoding
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // One register-file write: destination and value ("reg" is a keyword, hence wreg).
  typedef struct packed {
    logic [REG_ADDR_W-1:0] wreg;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_HEAD = 2'd2
  } wb_gnt_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter bus: pipeline/long-unit requests, scoreboard, regfile write port
//
// slave  : arbiter side (consumes requests, drives the register file write port)
// master : environment side (pipeline, long unit, issue logic, decode)
// Optional macro WB_FWD_EN adds fwd_rd1/fwd_rd2 (in) and fwd_hit1/fwd_hit2 (out).
interface wb_arbiter_if;
  import cpu_pkg::*;

  logic                  pipe_wr_en;
  logic [REG_ADDR_W-1:0] pipe_wr_reg;
  logic [DATA_W-1:0]     pipe_wr_data;
  logic                  pipe_stall;
  logic                  lu_valid;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_reg;
  logic [DATA_W-1:0]     lu_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_reg;
  logic [NUM_REGS-1:0]   busy;
  logic [REG_ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0]     writeData;
  logic                  regWrite;
`ifdef WB_FWD_EN
  logic [REG_ADDR_W-1:0] fwd_rd1;
  logic [REG_ADDR_W-1:0] fwd_rd2;
  logic                  fwd_hit1;
  logic                  fwd_hit2;
`endif

  modport slave (
    input  pipe_wr_en, pipe_wr_reg, pipe_wr_data,
    input  lu_valid, lu_reg, lu_data,
    input  issue_valid, issue_reg,
    output pipe_stall, lu_ready, busy,
    output writeReg, writeData, regWrite
`ifdef WB_FWD_EN
    , input fwd_rd1, fwd_rd2,
    output fwd_hit1, fwd_hit2
`endif
  );

  modport master (
    output pipe_wr_en, pipe_wr_reg, pipe_wr_data,
    output lu_valid, lu_reg, lu_data,
    output issue_valid, issue_reg,
    input  pipe_stall, lu_ready, busy,
    input  writeReg, writeData, regWrite
`ifdef WB_FWD_EN
    , output fwd_rd1, fwd_rd2,
    input fwd_hit1, fwd_hit2
`endif
  );

endinterface

// File: rtl/wb_lu_fifo.sv
// rtl/wb_lu_fifo.sv - circular buffer of long-unit writeback results
//
// Ports: clk, rst (sync active-high), push_i/push_data_i (enqueue), pop_i (dequeue head),
//        head_o (oldest entry), count_o (occupancy 0..DEPTH), empty_o.
// DEPTH must be a power of two >= 2 so the pointers wrap by plain overflow.
// The caller never pushes when full nor pops when empty.
module wb_lu_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  wb_req_t                  push_data_i,
  input  logic                     pop_i,
  output wb_req_t                  head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register file write-port arbiter with long-unit buffer, starvation stall and busy scoreboard
//
// Ports: clk, rst (sync active-high), bus (wb_arbiter_if.slave):
//   pipe_wr_en/pipe_wr_reg/pipe_wr_data in, pipe_stall out (registered)
//   lu_valid/lu_reg/lu_data in, lu_ready out (buffer not full)
//   issue_valid/issue_reg in, busy[31:0] out (outstanding long-unit destinations)
//   writeReg/writeData/regWrite out (registered, committed by the regfile at negedge)
// Optional macro WB_FWD_EN: fwd_rd1/fwd_rd2 in, fwd_hit1/fwd_hit2 out (hit on the in-flight write).
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int LU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int CW    = $clog2(LU_DEPTH) + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t               lu_req, head, sel;
  logic [CW-1:0]         count;
  logic                  empty, push, pop;
  wb_gnt_e               gnt;

  logic                  regWrite_q, regWrite_d;
  logic [REG_ADDR_W-1:0] writeReg_q, writeReg_d;
  logic [DATA_W-1:0]     writeData_q, writeData_d;
  logic                  stall_q, stall_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  assign lu_req.wreg  = bus.lu_reg;
  assign lu_req.data  = bus.lu_data;
  // Ready comes from the pre-pop count, so a full buffer never accepts even while popping.
  assign bus.lu_ready = (count != CW'(LU_DEPTH));
  assign push         = bus.lu_valid && bus.lu_ready;
  assign pop          = (gnt == GNT_HEAD);

  wb_lu_fifo #(.DEPTH(LU_DEPTH)) u_lu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (lu_req),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty)
  );

  // A stall cycle belongs to the buffer head; upstream re-presents its write afterwards.
  always_comb begin
    gnt = GNT_NONE;
    if (stall_q && !empty)   gnt = GNT_HEAD;
    else if (bus.pipe_wr_en) gnt = GNT_PIPE;
    else if (!empty)         gnt = GNT_HEAD;
  end

  // Writes to r0 are consumed but never reach the register file.
  always_comb begin
    sel.wreg    = bus.pipe_wr_reg;
    sel.data    = bus.pipe_wr_data;
    if (gnt == GNT_HEAD) sel = head;
    regWrite_d  = (gnt != GNT_NONE) && (sel.wreg != REG_ZERO);
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    if (gnt != GNT_NONE) begin
      writeReg_d  = sel.wreg;
      writeData_d = sel.data;
    end
  end

  // Counts consecutive lost arbitrations of a waiting head. The loss that brings it to
  // STARVE_LIMIT raises pipe_stall for the following cycle and restarts the count.
  always_comb begin
    stall_d = 1'b0;
    cnt_d   = '0;
    if (!empty && !pop) begin
      if (cnt_q == CNT_W'(STARVE_LIMIT - 1)) stall_d = 1'b1;
      else                                   cnt_d   = cnt_q + 1'b1;
    end
  end

  // Clear on head retirement first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (pop)             busy_d[head.wreg]     = 1'b0;
    if (bus.issue_valid) busy_d[bus.issue_reg] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
      stall_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= '0;
    end else begin
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
      stall_q     <= stall_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.regWrite   = regWrite_q;
  assign bus.writeReg   = writeReg_q;
  assign bus.writeData  = writeData_q;
  assign bus.pipe_stall = stall_q;
  assign bus.busy       = busy_q;

`ifdef WB_FWD_EN
  assign bus.fwd_hit1 = regWrite_q && (writeReg_q == bus.fwd_rd1) && (writeReg_q != REG_ZERO);
  assign bus.fwd_hit2 = regWrite_q && (writeReg_q == bus.fwd_rd2) && (writeReg_q != REG_ZERO);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized bench for wb_arbiter against a queue-based model
module tb_wb_arbiter;
  import cpu_pkg::*;

  localparam int LU_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.LU_DEPTH(LU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: results waiting for the port in arrival order, busy set, losses of the oldest result.
  wb_req_t             mq[$];
  logic [NUM_REGS-1:0] m_busy       = '0;
  int                  m_lose       = 0;
  bit                  m_stall      = 1'b0;
  bit                  m_prev_stall = 1'b0;
`ifdef WB_FWD_EN
  int                  fwd_pin      = -1;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy       = '0;
    m_lose       = 0;
    m_stall      = 1'b0;
    m_prev_stall = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_regWrite"},  bus.regWrite,   0);
    check_eq({tag, "_writeReg"},  bus.writeReg,   0);
    check_eq({tag, "_writeData"}, bus.writeData,  0);
    check_eq({tag, "_busy"},      bus.busy,       0);
    check_eq({tag, "_lu_ready"},  bus.lu_ready,   1);
    check_eq({tag, "_pipe_stall"},bus.pipe_stall, 0);
  endtask

  // One clock cycle: drive, predict from the rules, clock, compare. Entered at posedge+1.
  task automatic cyc(input bit pe, input logic [4:0] pr, input logic [31:0] pd,
                     input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                     input bit iv, input logic [4:0] ir);
    wb_req_t w;
    bit hw, pw, acc, ns, exp_rw;
    // Upstream re-presents the write that a stall cycle ignored.
    if (!m_prev_stall) begin
      bus.pipe_wr_en   = pe;
      bus.pipe_wr_reg  = pr;
      bus.pipe_wr_data = pd;
    end
    bus.lu_valid    = lv;
    bus.lu_reg      = lr;
    bus.lu_data     = ld;
    bus.issue_valid = iv;
    bus.issue_reg   = ir;
`ifdef WB_FWD_EN
    bus.fwd_rd1 = (fwd_pin >= 0) ? 5'(fwd_pin) : 5'($urandom_range(0, 7));
    bus.fwd_rd2 = 5'($urandom_range(0, 7));
`endif
    #1;
    check_eq("lu_ready",    bus.lu_ready,   (mq.size() < LU_DEPTH));
    check_eq("pipe_stall",  bus.pipe_stall, m_stall);
    check_eq("stall_empty", (bus.pipe_stall && mq.size() == 0), 0);

    hw  = (mq.size() > 0) && (m_stall || !bus.pipe_wr_en);
    pw  = !hw && bus.pipe_wr_en;
    acc = bus.lu_valid && (mq.size() < LU_DEPTH);
    ns  = 1'b0;
    if (mq.size() > 0 && !hw) begin
      m_lose++;
      if (m_lose == STARVE_LIMIT) begin
        ns     = 1'b1;
        m_lose = 0;
      end
    end else begin
      m_lose = 0;
    end
    w.wreg = bus.pipe_wr_reg;
    w.data = bus.pipe_wr_data;
    if (hw) begin
      w = mq.pop_front();
      m_busy[w.wreg] = 1'b0;
    end
    if (acc) mq.push_back(wb_req_t'{wreg: bus.lu_reg, data: bus.lu_data});
    if (bus.issue_valid && bus.issue_reg != 0) m_busy[bus.issue_reg] = 1'b1;
    exp_rw = (hw || pw) && (w.wreg != 0);

    @(posedge clk);
    #1;
    check_eq("regWrite", bus.regWrite, exp_rw);
    if (exp_rw) begin
      check_eq("writeReg",  bus.writeReg,  w.wreg);
      check_eq("writeData", bus.writeData, w.data);
    end
    check_eq("busy", bus.busy, m_busy);
`ifdef WB_FWD_EN
    check_eq("fwd_hit1", bus.fwd_hit1, exp_rw && (w.wreg == bus.fwd_rd1));
    check_eq("fwd_hit2", bus.fwd_hit2, exp_rw && (w.wreg == bus.fwd_rd2));
`endif
    m_prev_stall = m_stall;
    m_stall      = ns;
  endtask

  task automatic rand_cyc();
    cyc(($urandom % 4) != 0, 5'($urandom_range(0, 7)), $urandom,
        1'($urandom), 5'($urandom_range(0, 7)), $urandom,
        ($urandom % 3) == 0, 5'($urandom_range(0, 7)));
  endtask

  initial begin
    rst              = 1'b1;
    bus.pipe_wr_en   = 1'b1;
    bus.pipe_wr_reg  = 5'd4;
    bus.pipe_wr_data = 32'h5555_5555;
    bus.lu_valid     = 1'b0;
    bus.lu_reg       = '0;
    bus.lu_data      = '0;
    bus.issue_valid  = 1'b0;
    bus.issue_reg    = '0;
`ifdef WB_FWD_EN
    bus.fwd_rd1 = '0;
    bus.fwd_rd2 = '0;
`endif

    // Reset held with a pending pipeline write
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_state("rst");
    end
    rst = 1'b0;
    model_reset();

    // Pipeline only, including r0
    cyc(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0);
    check_eq("t_pipe_reg",  bus.writeReg,  5);
    check_eq("t_pipe_data", bus.writeData, 32'h1234);
    check_eq("t_pipe_we",   bus.regWrite,  1);
    cyc(1, 5'd0, 32'hAAAA, 0, 0, 0, 0, 0);
    check_eq("t_r0_we", bus.regWrite, 0);

    // Idle-slot drain clears busy
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd9);
    check_eq("t_busy9_set", bus.busy[9], 1);
    cyc(0, 0, 0, 1, 5'd9, 32'hDEAD, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t_drain_reg",  bus.writeReg,  9);
    check_eq("t_drain_data", bus.writeData, 32'hDEAD);
    check_eq("t_busy9_clr",  bus.busy[9],   0);

    // Starvation: r3 loses STARVE_LIMIT times, then a one-cycle stall retires it
    cyc(1, 5'd11, 32'h100, 1, 5'd3, 32'h33, 0, 0);
    for (int i = 1; i <= STARVE_LIMIT; i++) cyc(1, 5'd11, 32'h100 + i, 0, 0, 0, 0, 0);
    check_eq("t_starve_stall", bus.pipe_stall, 1);
    cyc(1, 5'd11, 32'h105, 0, 0, 0, 0, 0);
    check_eq("t_starve_reg",   bus.writeReg,   3);
    check_eq("t_starve_data",  bus.writeData,  32'h33);
    check_eq("t_stall_one",    bus.pipe_stall, 0);
    cyc(1, 5'd12, 32'h106, 0, 0, 0, 0, 0);
    check_eq("t_held_reg",  bus.writeReg,  11);
    check_eq("t_held_data", bus.writeData, 32'h105);

    // Full buffer
    cyc(1, 5'd12, 32'h200, 1, 5'd20, 32'h2020, 0, 0);
    cyc(1, 5'd12, 32'h201, 1, 5'd21, 32'h2121, 0, 0);
    check_eq("t_full_ready", bus.lu_ready, 0);
    cyc(1, 5'd12, 32'h202, 1, 5'd22, 32'h2222, 0, 0);
    check_eq("t_full_ready2", bus.lu_ready, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t_pop_ready", bus.lu_ready, 1);
    check_eq("t_pop_reg",   bus.writeReg, 20);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t_pop2_reg",  bus.writeReg, 21);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t_no_r22", bus.regWrite, 0);

    // Same-cycle set and clear of r7
    cyc(0, 0, 0, 1, 5'd7, 32'h77, 0, 0);
`ifdef WB_FWD_EN
    fwd_pin = 7;
`endif
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd7);
    check_eq("t_race_reg",  bus.writeReg, 7);
    check_eq("t_race_busy", bus.busy[7],  1);
`ifdef WB_FWD_EN
    check_eq("t_fwd_hit1", bus.fwd_hit1, 1);
    fwd_pin = -1;
`endif

    // Randomized traffic, a mid-run reset, more traffic
    repeat (400) rand_cyc();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    rst = 1'b0;
    model_reset();
    repeat (200) rand_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writer side of the register file write port (writeReg / writeData / regWrite, sampled by the register file on negedge clk).
- Merges two result sources onto the single write port:
  - the in-order pipeline writeback (one write per cycle, highest priority);
  - the long-latency unit (mult/div) results, delivered over a valid/ready handshake and buffered.
- Also keeps a per-register busy scoreboard for outstanding long-latency ops, used by the hazard logic.

Parameters:
- LU_DEPTH, 2, long-unit result buffer entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive cycles the buffer head may lose arbitration before the pipeline is stalled

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- pipe_wr_en  in  1  pipeline writeback request this cycle
- pipe_wr_reg  in  5  pipeline destination register
- pipe_wr_data  in  32  pipeline result
- pipe_stall  out  1  registered; upstream must hold its writeback while high
- lu_valid  in  1  long-unit result valid
- lu_ready  out  1  buffer not full (combinational from count)
- lu_reg  in  5  long-unit destination register
- lu_data  in  32  long-unit result
- issue_valid  in  1  long op issued this cycle
- issue_reg  in  5  destination of the issued long op
- busy  out  32  scoreboard; bit r=1 while r awaits a long-unit result
- writeReg  out  5  to register file
- writeData  out  32  to register file
- regWrite  out  1  to register file

Behaviour:
- Reset values:
  - regWrite=0, writeReg=0, writeData=0.
  - pipe_stall=0, busy=0.
  - Buffer empty, so lu_ready=1; starve counter=0.
- Reset mid-operation flushes buffered results and clears busy.
- Output registers: requests granted at posedge N appear on writeReg/writeData/regWrite after posedge N. The register file commits at the negedge inside that cycle. Latency is 1 cycle.
- Buffer:
  - Circular FIFO of {reg, data}.
  - Push when lu_valid && lu_ready. Pop when the head is granted.
  - Push and pop in the same cycle is legal when full: lu_ready stays computed from the pre-pop count, so no push occurs when full.
  - Pointers wrap modulo LU_DEPTH.
- Arbitration, each cycle:
  - pipe_stall=1 and buffer non-empty: grant the buffer head. Any pipe_wr_en this cycle is ignored; upstream holds it.
  - Else if pipe_wr_en: grant the pipeline.
  - Else if buffer non-empty: grant the head.
  - Else regWrite=0.
- Register 0: a granted write to reg 0 is consumed (pop / accepted) but drives regWrite=0.
- Starvation:
  - The counter increments when the buffer is non-empty and the head is not granted. It clears on any head grant or when the buffer is empty.
  - When the counter reaches STARVE_LIMIT, pipe_stall is asserted next cycle for exactly one cycle. The counter then clears.
  - pipe_stall with an empty buffer (impossible by construction) is a bench assertion failure.
- Scoreboard:
  - issue_valid sets busy[issue_reg].
  - A granted buffer-head write clears busy[head reg].
  - Set and clear of the same register in the same cycle: set wins.
  - issue_reg=0 is ignored; busy[0] is always 0.
- A pipeline write to a busy register does not clear busy.

Optional Feature:
- WB_FWD_EN defined: add ports fwd_rd1 in 5, fwd_rd2 in 5, fwd_hit1 out 1, fwd_hit2 out 1.
  - fwd_hitN = regWrite && writeReg==fwd_rdN && writeReg!=0 (combinational).
  - Lets decode mux writeData ahead of the negedge commit.
- Undefined: these ports and this logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (cpu_pkg) holds:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, REG_ZERO=0;
  - a wb_req typedef {reg, data}.
- One natural sub-module: wb_lu_fifo (parameterised buffer: push/pop/count/full/empty). Arbiter, starve counter and scoreboard stay in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles with pipe_wr_en=1 -> regWrite=0, busy=0, lu_ready=1, pipe_stall=0 throughout.
- Pipeline only: pipe write r5=0x1234 at cycle N -> writeReg=5, writeData=0x1234, regWrite=1 during cycle N+1; a write to r0 yields regWrite=0.
- Idle slot drain: issue r9 (busy[9]=1), then lu result r9=0xDEAD with pipe idle -> written next cycle, busy[9]=0 the cycle after grant.
- Starvation: buffer holds r3, pipe_wr_en=1 every cycle, STARVE_LIMIT=4 -> pipe_stall=1 for one cycle, r3 written that cycle, pipeline write held and written next.
- Full buffer: LU_DEPTH=2, two lu pushes during pipeline writes -> lu_ready=0, third lu_valid not accepted; after one pop lu_ready=1.
- Set/clear race: issue_valid r7 in the same cycle the r7 buffer result is granted -> busy[7]=1 afterwards. With WB_FWD_EN, fwd_rd1=7 during that write -> fwd_hit1=1.
